// File: rtl/sccb_init_seq.sv
// -----------------------------------------------------------------------------
// sccb_init_seq
//   Camera register-init sequencer. Walks an external init table (synchronous
//   ROM/BRAM, one clk read latency) and issues one SCCB write per entry to the
//   downstream SCCB master. Table words:
//     32'h0000_0000          END of table
//     32'hFFFF_nnnn          DELAY of nnnn milliseconds
//     anything else          WRITE {ID[7:1],0,SubAddM,SubAddL,Data}
//   A per-transaction timeout guards against a stuck Busy.
//
//   Optional feature macro: SCCB_VERIFY_EN
//     When defined, every WRITE is followed by a read-back (op 01 then op 10)
//     and ReadData is compared with the written data byte.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   Go                 1-cycle start pulse (honoured only in IDLE/DONE/ERR)
//   Addr16             1 = 16-bit sub-address mode, sampled at Go
//   Tbl_Addr/Tbl_Data  init table read port
//   Start/WR/DataIn    command to the SCCB master; Busy/ReadData from it
//   Active/Done/Error  status; Err_Addr = table index of the failing entry
// -----------------------------------------------------------------------------
module sccb_init_seq #(
    parameter int ADDR_W     = 8,
    parameter int CLK_PER_MS = 100000,
    parameter int TMO_CYC    = 1048576
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              Go,
    input  logic              Addr16,
    output logic [ADDR_W-1:0] Tbl_Addr,
    input  logic [31:0]       Tbl_Data,
    output logic              Start,
    output logic [3:0]        WR,
    output logic [31:0]       DataIn,
    input  logic              Busy,
    input  logic [7:0]        ReadData,
    output logic              Active,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W-1:0] Err_Addr
);

    localparam int CYC_W = $clog2(CLK_PER_MS + 1);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_MS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_DELAY, S_ISSUE,
        S_WAIT_H, S_WAIT_L, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t           state;
    logic [31:0]      word;      // latched table entry
    logic             addr16_q;  // addressing mode for the whole sequence
    logic [CYC_W-1:0] cyc;       // clk count inside the current millisecond
    logic [15:0]      ms;        // elapsed milliseconds of a DELAY entry
    logic [TMO_W-1:0] tmo;       // clks spent waiting on the current transaction

`ifdef SCCB_VERIFY_EN
    logic [1:0] op;              // 00 write, 01 read phase1, 10 read phase2
    logic [7:0] wr_byte;
    // The data byte position inside DataIn depends on the sub-address width.
    assign wr_byte = addr16_q ? word[7:0] : word[15:8];
`else
    logic [1:0] op;
    logic       unused_read_data;
    assign op               = 2'b00;
    assign unused_read_data = ^ReadData;
`endif

    // NOTE: every register here, including the latched table word, is cleared
    // by the async reset so an abandoned transaction leaves no stale command.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            Tbl_Addr <= '0;
            Start    <= 1'b0;
            WR       <= '0;
            DataIn   <= '0;
            Active   <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
            Err_Addr <= '0;
            word     <= '0;
            addr16_q <= 1'b0;
            cyc      <= '0;
            ms       <= '0;
            tmo      <= '0;
`ifdef SCCB_VERIFY_EN
            op       <= 2'b00;
`endif
        end else begin
            // NOTE: non-blocking default keeps Start a single-cycle pulse;
            // only the ISSUE branch overrides it.
            Start <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Go) begin
                        state    <= S_FETCH;
                        Tbl_Addr <= '0;
                        Active   <= 1'b1;
                        Done     <= 1'b0;
                        Error    <= 1'b0;
                        Err_Addr <= '0;
                        addr16_q <= Addr16;
                    end
                end
                // The ROM registers Tbl_Addr during this clk; data is valid in DECODE.
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    word <= Tbl_Data;
                    cyc  <= '0;
                    ms   <= '0;
                    if (Tbl_Data == 32'h0000_0000) begin
                        state  <= S_DONE;
                        Done   <= 1'b1;
                        Active <= 1'b0;
                    end else if (Tbl_Data[31:16] == 16'hFFFF) begin
                        state <= (Tbl_Data[15:0] == 16'd0) ? S_NEXT : S_DELAY;
                    end else begin
                        state <= S_ISSUE;
`ifdef SCCB_VERIFY_EN
                        op    <= 2'b00;
`endif
                    end
                end
                S_DELAY: begin
                    if (cyc == CYC_LAST) begin
                        cyc <= '0;
                        if (ms == word[15:0] - 16'd1) state <= S_NEXT;
                        else                          ms    <= ms + 16'd1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                // Hold off while the master is still busy (e.g. a transaction
                // abandoned by a reset) so Start never overlaps Busy.
                S_ISSUE: begin
                    if (!Busy) begin
                        Start  <= 1'b1;
                        WR     <= {1'b0, addr16_q, op};
                        DataIn <= word;
                        tmo    <= '0;
                        state  <= S_WAIT_H;
                    end
                end
                S_WAIT_H: begin
                    if (Busy) begin
                        tmo   <= tmo + 1'b1;
                        state <= S_WAIT_L;
                    end else if (tmo >= TMO_LAST) begin
                        state    <= S_ERR;
                        Error    <= 1'b1;
                        Err_Addr <= Tbl_Addr;
                        Active   <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_WAIT_L: begin
                    if (!Busy) begin
`ifdef SCCB_VERIFY_EN
                        if (op == 2'b00) begin
                            op    <= 2'b01;
                            state <= S_ISSUE;
                        end else if (op == 2'b01) begin
                            op    <= 2'b10;
                            state <= S_ISSUE;
                        end else if (ReadData == wr_byte) begin
                            state <= S_NEXT;
                        end else begin
                            state    <= S_ERR;
                            Error    <= 1'b1;
                            Err_Addr <= Tbl_Addr;
                            Active   <= 1'b0;
                        end
`else
                        state <= S_NEXT;
`endif
                    end else if (tmo >= TMO_LAST) begin
                        state    <= S_ERR;
                        Error    <= 1'b1;
                        Err_Addr <= Tbl_Addr;
                        Active   <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                // The last table slot ends the sequence instead of wrapping to 0.
                S_NEXT: begin
                    if (Tbl_Addr == '1) begin
                        state  <= S_DONE;
                        Done   <= 1'b1;
                        Active <= 1'b0;
                    end else begin
                        Tbl_Addr <= Tbl_Addr + 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// -----------------------------------------------------------------------------
// tb_sccb_init_seq
//   Directed bench for sccb_init_seq with ADDR_W=2, CLK_PER_MS=100, TMO_CYC=64.
//   Contains a synchronous table ROM and a simple SCCB slave model (Busy high
//   for a fixed number of clks, one-register read-back store).
// -----------------------------------------------------------------------------
module tb_sccb_init_seq;

    localparam int ADDR_W     = 2;
    localparam int CLK_PER_MS = 100;
    localparam int TMO_CYC    = 64;
`ifdef SCCB_VERIFY_EN
    localparam int OPS = 3;  // write + two read-back phases per entry
`else
    localparam int OPS = 1;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              go = 1'b0;
    logic              addr16 = 1'b0;
    logic [ADDR_W-1:0] tbl_addr;
    logic [31:0]       tbl_data = '0;
    logic              start;
    logic [3:0]        wr;
    logic [31:0]       datain;
    logic              busy = 1'b0;
    logic [7:0]        read_data = '0;
    logic              active, done, error;
    logic [ADDR_W-1:0] err_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sccb_init_seq #(
        .ADDR_W(ADDR_W), .CLK_PER_MS(CLK_PER_MS), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rstn(rstn), .Go(go), .Addr16(addr16),
        .Tbl_Addr(tbl_addr), .Tbl_Data(tbl_data),
        .Start(start), .WR(wr), .DataIn(datain),
        .Busy(busy), .ReadData(read_data),
        .Active(active), .Done(done), .Error(error), .Err_Addr(err_addr)
    );

    // Synchronous init table
    logic [31:0] rom [4];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // SCCB slave model and Start logger
    bit          busy_resp = 1'b1;
    int          busy_len = 50;
    int          busy_cnt = 0;
    logic [7:0]  reg_byte = '0;
    logic [7:0]  corrupt = '0;
    int          n_start = 0;
    logic [3:0]  log_wr [64];
    logic [31:0] log_data [64];
    int          start_busy_err = 0;
    int          wide_err = 0;
    logic        start_q = 1'b0;

    always @(posedge clk) begin
        start_q <= start;
        if (start && busy)    start_busy_err <= start_busy_err + 1;
        if (start && start_q) wide_err <= wide_err + 1;
        if (start) begin
            if (n_start < 64) begin
                log_wr[n_start]   <= wr;
                log_data[n_start] <= datain;
            end
            n_start <= n_start + 1;
            if (wr[1:0] == 2'b00) reg_byte <= wr[2] ? datain[7:0] : datain[15:8];
            if (wr[1:0] == 2'b10) read_data <= reg_byte ^ corrupt;
        end
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) busy <= 1'b0;
        end else if (start && busy_resp) begin
            busy     <= 1'b1;
            busy_cnt <= busy_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done | error), 32'd1);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        while (!start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(start), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        int m;

        for (int i = 0; i < 4; i++) rom[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_start",    32'(start),    32'd0);
        check("rst_active",   32'(active),   32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        check("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        check("rst_wr",       32'(wr),       32'd0);
        check("rst_datain",   datain,        32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // T1: two writes then END, 8-bit sub-address
        rom[0] = 32'h4230_1280; rom[1] = 32'h4231_0300; rom[2] = 32'h0; rom[3] = 32'h0;
        addr16 = 1'b0;
        base = n_start;
        pulse_go();
        check("t1_active", 32'(active), 32'd1);
        wait_end("t1_end", 2000);
        check("t1_done",     32'(done),         32'd1);
        check("t1_error",    32'(error),        32'd0);
        check("t1_active_0", 32'(active),       32'd0);
        check("t1_tbl_addr", 32'(tbl_addr),     32'd2);
        check("t1_starts",   n_start - base,    2 * OPS);
        check("t1_wr0",      32'(log_wr[base]), 32'h0);
        check("t1_data0",    log_data[base],    32'h4230_1280);
        check("t1_wr1",      32'(log_wr[base + OPS]), 32'h0);
        check("t1_data1",    log_data[base + OPS],    32'h4231_0300);

        // T2: 2 ms delay then 0 ms delay then END. Address step = FETCH + DECODE
        // + delay clks + NEXT, i.e. 3 + 200 for the 2 ms entry and 3 for 0 ms.
        rom[0] = 32'hFFFF_0002; rom[1] = 32'hFFFF_0000; rom[2] = 32'h0;
        base = n_start;
        pulse_go();
        n = 0;
        while (tbl_addr != 2'd1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t2_delay2_clks", n, 203);
        m = 0;
        while (tbl_addr != 2'd2 && m < 100) begin
            @(negedge clk);
            m++;
        end
        check("t2_delay0_clks", m, 3);
        wait_end("t2_end", 100);
        check("t2_done",   32'(done),      32'd1);
        check("t2_starts", n_start - base, 0);

        // T3: Busy never rises; write at entry 1 times out 64 clks after Start
        busy_resp = 1'b0;
        rom[0] = 32'hFFFF_0000; rom[1] = 32'h4230_1280; rom[2] = 32'h0;
        pulse_go();
        wait_start("t3_start", 100);
        n = 0;
        while (!error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t3_tmo_clks", n,               64);
        check("t3_error",    32'(error),      32'd1);
        check("t3_err_addr", 32'(err_addr),   32'd1);
        check("t3_active",   32'(active),     32'd0);
        check("t3_done",     32'(done),       32'd0);
        busy_resp = 1'b1;

        // T4: Go clears the error; reset while waiting for Busy to fall
        rom[0] = 32'h4230_1280; rom[1] = 32'h4231_0300; rom[2] = 32'h0;
        pulse_go();
        check("t4_err_clr",      32'(error),    32'd0);
        check("t4_err_addr_clr", 32'(err_addr), 32'd0);
        wait_start("t4_start", 100);
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4_busy_high", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        check("t4_active_mid", 32'(active), 32'd1);
        rstn = 1'b0;
        #1;
        check("t4_rst_start",    32'(start),    32'd0);
        check("t4_rst_active",   32'(active),   32'd0);
        check("t4_rst_done",     32'(done),     32'd0);
        check("t4_rst_error",    32'(error),    32'd0);
        check("t4_rst_tbl_addr", 32'(tbl_addr), 32'd0);
        check("t4_rst_wr",       32'(wr),       32'd0);
        check("t4_rst_datain",   datain,        32'd0);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_busy_low", 32'(busy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        base = n_start;
        pulse_go();
        wait_end("t4_end", 2000);
        check("t4_done",   32'(done),      32'd1);
        check("t4_starts", n_start - base, 2 * OPS);
        check("t4_data0",  log_data[base], 32'h4230_1280);

        // T6: 16-bit mode, no END in a 4-entry table; Addr16 dropped after Go
        rom[0] = 32'h7830_0811; rom[1] = 32'h7830_0812;
        rom[2] = 32'h7830_0813; rom[3] = 32'h7830_0814;
        addr16 = 1'b1;
        base = n_start;
        pulse_go();
        addr16 = 1'b0;
        wait_end("t6_end", 5000);
        check("t6_done",     32'(done),     32'd1);
        check("t6_error",    32'(error),    32'd0);
        check("t6_tbl_addr", 32'(tbl_addr), 32'd3);
        check("t6_starts",   n_start - base, 4 * OPS);
        check("t6_wr0",      32'(log_wr[base]), 32'b0100);
        check("t6_data0",    log_data[base],    32'h7830_0811);
        check("t6_wr3",      32'(log_wr[base + 3 * OPS]), 32'b0100);
        check("t6_data3",    log_data[base + 3 * OPS],    32'h7830_0814);

`ifdef SCCB_VERIFY_EN
        // T5: read-back matches (0x80), then mismatch (0x81) at entry 1
        rom[0] = 32'h4230_1280; rom[1] = 32'h0; rom[2] = 32'h0; rom[3] = 32'h0;
        addr16 = 1'b1;
        corrupt = 8'h00;
        base = n_start;
        pulse_go();
        wait_end("t5_end", 2000);
        check("t5_done",  32'(done),      32'd1);
        check("t5_starts", n_start - base, 3);
        check("t5_op0",   32'(log_wr[base]),     32'b0100);
        check("t5_op1",   32'(log_wr[base + 1]), 32'b0101);
        check("t5_op2",   32'(log_wr[base + 2]), 32'b0110);
        check("t5_data1", log_data[base + 1],    32'h4230_1280);
        rom[0] = 32'hFFFF_0000; rom[1] = 32'h4230_1280; rom[2] = 32'h0;
        corrupt = 8'h01;
        pulse_go();
        wait_end("t5_err_end", 2000);
        check("t5_error",    32'(error),    32'd1);
        check("t5_err_addr", 32'(err_addr), 32'd1);
        check("t5_done_0",   32'(done),     32'd0);
        check("t5_active",   32'(active),   32'd0);
        corrupt = 8'h00;
`endif

        // Protocol invariants observed over the whole run
        check("start_while_busy", start_busy_err, 0);
        check("start_wide",       wide_err,       0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
